// File: rtl/fft8_pkg.sv
// -----------------------------------------------------------------------------
// fft8_pkg
// Shared definitions for the 8-point FFT datapath and its front-end loader.
//   FFT_N / LOG2N   : transform size and index width
//   DEFAULT_DATA_W  : packed complex sample width
//   cfp16_t         : complex fp16 layout, real in [31:16], imaginary in [15:0]
//   loader_state_t  : frame loader FSM encoding
//   bitrev3()       : 3-bit index bit reversal used for bit-reversed frame order
// -----------------------------------------------------------------------------
package fft8_pkg;

  localparam int FFT_N          = 8;
  localparam int LOG2N          = 3;
  localparam int FP16_W         = 16;
  localparam int DEFAULT_DATA_W = 2 * FP16_W;

  // Field order in a packed struct runs MSB first, so re lands in [31:16].
  typedef struct packed {
    logic [FP16_W-1:0] re;
    logic [FP16_W-1:0] im;
  } cfp16_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_t;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/fft8_frame_loader.sv
// -----------------------------------------------------------------------------
// fft8_frame_loader
// Collects a serial stream of complex samples into 8-sample frames and presents
// each frame on eight parallel words for fft8_fp. A frame stays on the outputs
// for at least HOLD_CYCLES+1 cycles; meanwhile the next frame fills a one-deep
// buffer. If that buffer completes before the hold window expires, intake
// stalls (FULL) until the output can take it.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   s_data       input sample {re fp16, im fp16}
//   s_valid      s_data is valid
//   s_last       last sample of a frame (early s_last drops the frame)
//   s_ready      sample is accepted on this cycle's edge when s_valid is high
//   out1..out8   presented frame; out1 = stream sample 0 in natural order
//   frame_valid  one-cycle pulse in the first cycle of a new frame on out*
//   frame_err    one-cycle pulse after a frame was dropped on early s_last
//   frame_cnt    frames presented since reset, wraps
// -----------------------------------------------------------------------------
module fft8_frame_loader
  import fft8_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int HOLD_CYCLES = 7,
  parameter bit BIT_REV     = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic [DATA_W-1:0] out8,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [LOG2N-1:0] IDX_LAST    = LOG2N'(FFT_N - 1);
  localparam logic [7:0]       HOLD_RELOAD = 8'(HOLD_CYCLES);

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [LOG2N-1:0]  idx;
  logic [7:0]        hold_cnt;
  logic [DATA_W-1:0] fill_q    [FFT_N];
  logic [DATA_W-1:0] out_q     [FFT_N];
  logic [DATA_W-1:0] frame_src [FFT_N];
  logic [DATA_W-1:0] frame_map [FFT_N];

  logic accept;
  logic idx_at_last;
  logic hold_free;
  logic complete;
  logic drop;
  logic xfer_fill;
  logic xfer_full;
  logic xfer;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  assign accept      = s_valid && s_ready;
  assign idx_at_last = (idx == IDX_LAST);
  assign hold_free   = (hold_cnt == 8'd0);
  // s_last on the 8th sample is redundant and ignored; earlier it aborts.
  assign complete    = accept && idx_at_last;
  assign drop        = accept && s_last && !idx_at_last;
  // A completed frame goes straight to the outputs if the hold window is over,
  // otherwise it waits in the fill buffer (FULL) for the window to close.
  assign xfer_fill   = complete && hold_free;
  assign xfer_full   = (state == FULL) && hold_free;
  assign xfer        = xfer_fill || xfer_full;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first so no path through the block leaves
  // state_nxt unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (complete && !hold_free) state_nxt = FULL;
      FULL:    if (hold_free)              state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Ready depends only on the state register and reset, never on s_valid, so
  // upstream sees no combinational path back through this block.
  always_comb begin
    s_ready = (state == FILL) && !rst;
  end

  // ---------------------------------------------------------------------------
  // Frame assembly and output ordering
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < FFT_N; i++) begin
      frame_src[i] = fill_q[i];
    end
    // On a direct transfer the 8th sample has not reached the buffer yet.
    if (xfer_fill) begin
      frame_src[FFT_N-1] = s_data;
    end
  end

  // Stream index i drives output bitrev3(i). Since bitrev3 is its own inverse,
  // output p simply reads stream index bitrev3(p).
  always_comb begin
    for (int p = 0; p < FFT_N; p++) begin
      frame_map[p] = BIT_REV ? frame_src[bitrev3(LOG2N'(p))] : frame_src[p];
    end
  end

  // ---------------------------------------------------------------------------
  // Fill buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer is left out of reset: every entry is rewritten before it
  // can reach the outputs, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      fill_q[idx] <= s_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Index, hold counter, outputs, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      hold_cnt    <= 8'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      for (int i = 0; i < FFT_N; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      frame_valid <= xfer;
      frame_err   <= drop;

      if (accept) begin
        idx <= (drop || idx_at_last) ? '0 : idx + LOG2N'(1);
      end

      // Reload on transfer takes priority over the countdown.
      if (xfer) begin
        hold_cnt <= HOLD_RELOAD;
      end else if (!hold_free) begin
        hold_cnt <= hold_cnt - 8'd1;
      end

      if (xfer) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        for (int i = 0; i < FFT_N; i++) begin
          out_q[i] <= frame_map[i];
        end
      end
    end
  end

  assign out1 = out_q[0];
  assign out2 = out_q[1];
  assign out3 = out_q[2];
  assign out4 = out_q[3];
  assign out5 = out_q[4];
  assign out6 = out_q[5];
  assign out7 = out_q[6];
  assign out8 = out_q[7];

endmodule

// File: tb/tb_fft8_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_fft8_frame_loader
// Directed bench for fft8_frame_loader. Four instances share clk/rst:
//   0: defaults            1: BIT_REV = 1
//   2: HOLD_CYCLES = 12    3: CNT_W = 2
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_fft8_frame_loader;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data  [ND];
  logic        s_valid [ND];
  logic        s_last  [ND];
  logic        s_ready [ND];
  logic [31:0] o       [ND][8];
  logic        fv      [ND];
  logic        fe      [ND];
  logic [15:0] fc      [ND];

  int errors = 0;
  int checks = 0;
  int stalls = 0;

  logic [31:0] v1     [8] = '{32'h3c000000, 32'h40000000, 32'h42000000, 32'h44000000,
                              32'h44000000, 32'h42000000, 32'h40000000, 32'h3c000000};
  int          br_exp [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int          wr_exp [5] = '{1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int HC = (g == 2) ? 12 : 7;
    localparam bit BR = (g == 1);
    localparam int CW = (g == 3) ? 2 : 16;
    logic [CW-1:0] cnt;
    fft8_frame_loader #(
      .DATA_W(32), .HOLD_CYCLES(HC), .BIT_REV(BR), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst(rst),
      .s_data(s_data[g]), .s_valid(s_valid[g]), .s_last(s_last[g]), .s_ready(s_ready[g]),
      .out1(o[g][0]), .out2(o[g][1]), .out3(o[g][2]), .out4(o[g][3]),
      .out5(o[g][4]), .out6(o[g][5]), .out7(o[g][6]), .out8(o[g][7]),
      .frame_valid(fv[g]), .frame_err(fe[g]), .frame_cnt(cnt)
    );
    assign fc[g] = 16'(cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic push(input int d, input logic [31:0] v, input logic last);
    bit ok = 1'b0;
    s_data[d]  = v;
    s_valid[d] = 1'b1;
    s_last[d]  = last;
    if (!s_ready[d]) stalls++;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (s_ready[d]) ok = 1'b1;
      step();
    end
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_timeout dut=%0d: sample %h not accepted within 64 cycles", d, v);
    end
  endtask

  task automatic push_frame(input int d, input logic [31:0] base);
    for (int i = 0; i < 8; i++) push(d, base + 32'(i), i == 7);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (s_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_ready dut=%0d: got %b expected 0", d, s_ready[d]); end
      checks++;
      if (fv[d] !== 1'b0 || fe[d] !== 1'b0) begin errors++; $display("FAIL reset_pulses dut=%0d: got fv=%b fe=%b expected 0 0", d, fv[d], fe[d]); end
      checks++;
      if (fc[d] !== 16'd0) begin errors++; $display("FAIL reset_cnt dut=%0d: got %0d expected 0", d, fc[d]); end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (o[d][i] !== 32'h0) begin errors++; $display("FAIL reset_out%0d dut=%0d: got %h expected 0", i + 1, d, o[d][i]); end
      end
    end
    rst = 1'b0;
    step();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (s_ready[d] !== 1'b1) begin errors++; $display("FAIL post_reset_ready dut=%0d: got %b expected 1", d, s_ready[d]); end
    end
  endtask

  task automatic test_stream();
    int fv_cnt = 0;
    do_reset();
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      push(0, v1[i], i == 7);
      if (i < 7) fv_cnt += int'(fv[0]);
    end
    checks++;
    if (stalls !== 0) begin errors++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
    checks++;
    if (fv_cnt !== 0) begin errors++; $display("FAIL stream_early_fv: got %0d pulses expected 0", fv_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o[0][i] !== v1[i]) begin errors++; $display("FAIL stream_out%0d: got %h expected %h", i + 1, o[0][i], v1[i]); end
    end
    checks++;
    if (fv[0] !== 1'b1) begin errors++; $display("FAIL stream_fv: got %b expected 1", fv[0]); end
    checks++;
    if (fc[0] !== 16'd1) begin errors++; $display("FAIL stream_cnt: got %0d expected 1", fc[0]); end
    checks++;
    if (s_ready[0] !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b expected 1", s_ready[0]); end
    step();
    checks++;
    if (fv[0] !== 1'b0) begin errors++; $display("FAIL stream_fv_width: got %b expected 0", fv[0]); end
    checks++;
    if (o[0][0] !== v1[0]) begin errors++; $display("FAIL stream_hold: got %h expected %h", o[0][0], v1[0]); end
  endtask

  task automatic test_bitrev();
    do_reset();
    for (int i = 0; i < 8; i++) push(1, 32'(i), i == 7);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o[1][i] !== 32'(br_exp[i])) begin errors++; $display("FAIL bitrev_out%0d: got %h expected %h", i + 1, o[1][i], br_exp[i]); end
    end
    checks++;
    if (fv[1] !== 1'b1) begin errors++; $display("FAIL bitrev_fv: got %b expected 1", fv[1]); end
  endtask

  task automatic test_hold();
    int n = 0;
    bit stable = 1'b1;
    bit extra_fv = 1'b0;
    do_reset();
    stalls = 0;
    push_frame(2, 32'h100);
    checks++;
    if (fv[2] !== 1'b1) begin errors++; $display("FAIL hold_fv1: got %b expected 1", fv[2]); end
    push_frame(2, 32'h200);
    checks++;
    if (stalls !== 0) begin errors++; $display("FAIL hold_stalls: got %0d expected 0", stalls); end
    // Frame 1 arrived at edge k; frame 2 completes at k+8 and must wait until
    // the hold counter (12 at k) reaches 0, i.e. transfer at edge k+13.
    while (!s_ready[2] && n < 40) begin
      for (int i = 0; i < 8; i++) if (o[2][i] !== 32'h100 + 32'(i)) stable = 1'b0;
      if (fv[2]) extra_fv = 1'b1;
      step();
      n++;
    end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL hold_stall_len: got %0d cycles expected 5", n); end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable: got %b expected 1", stable); end
    checks++;
    if (extra_fv !== 1'b0) begin errors++; $display("FAIL hold_extra_fv: got %b expected 0", extra_fv); end
    checks++;
    if (fv[2] !== 1'b1) begin errors++; $display("FAIL hold_fv2: got %b expected 1", fv[2]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o[2][i] !== 32'h200 + 32'(i)) begin errors++; $display("FAIL hold_out%0d: got %h expected %h", i + 1, o[2][i], 32'h200 + 32'(i)); end
    end
    checks++;
    if (fc[2] !== 16'd2) begin errors++; $display("FAIL hold_cnt: got %0d expected 2", fc[2]); end
    step();
    checks++;
    if (fv[2] !== 1'b0) begin errors++; $display("FAIL hold_fv2_width: got %b expected 0", fv[2]); end
  endtask

  task automatic test_drop();
    int fv_cnt = 0;
    int fe_cnt = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(0, 32'h500 + 32'(i), i == 4);
      fv_cnt += int'(fv[0]);
      if (i < 4) fe_cnt += int'(fe[0]);
    end
    checks++;
    if (fe[0] !== 1'b1) begin errors++; $display("FAIL drop_fe: got %b expected 1", fe[0]); end
    for (int i = 0; i < 8; i++) begin
      push(0, 32'h600 + 32'(i), i == 7);
      fe_cnt += int'(fe[0]);
      if (i < 7) fv_cnt += int'(fv[0]);
    end
    checks++;
    if (fe_cnt !== 0) begin errors++; $display("FAIL drop_fe_extra: got %0d pulses expected 0", fe_cnt); end
    checks++;
    if (fv_cnt !== 0) begin errors++; $display("FAIL drop_fv_extra: got %0d pulses expected 0", fv_cnt); end
    checks++;
    if (fv[0] !== 1'b1) begin errors++; $display("FAIL drop_fv: got %b expected 1", fv[0]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o[0][i] !== 32'h600 + 32'(i)) begin errors++; $display("FAIL drop_out%0d: got %h expected %h", i + 1, o[0][i], 32'h600 + 32'(i)); end
    end
    checks++;
    if (fc[0] !== 16'd1) begin errors++; $display("FAIL drop_cnt: got %0d expected 1", fc[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_frame(0, 32'h700);
    for (int i = 0; i < 4; i++) push(0, 32'h800 + 32'(i), 1'b0);
    rst = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o[0][i] !== 32'h0) begin errors++; $display("FAIL midrst_out%0d: got %h expected 0", i + 1, o[0][i]); end
    end
    checks++;
    if (fc[0] !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", fc[0]); end
    checks++;
    if (fv[0] !== 1'b0 || fe[0] !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got fv=%b fe=%b expected 0 0", fv[0], fe[0]); end
    checks++;
    if (s_ready[0] !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", s_ready[0]); end
    rst = 1'b0;
    step();
    checks++;
    if (fv[0] !== 1'b0 || fe[0] !== 1'b0) begin errors++; $display("FAIL midrst_pulses_after: got fv=%b fe=%b expected 0 0", fv[0], fe[0]); end
    push_frame(0, 32'h900);
    checks++;
    if (fv[0] !== 1'b1) begin errors++; $display("FAIL midrst_fv: got %b expected 1", fv[0]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o[0][i] !== 32'h900 + 32'(i)) begin errors++; $display("FAIL midrst_out%0d_new: got %h expected %h", i + 1, o[0][i], 32'h900 + 32'(i)); end
    end
    checks++;
    if (fc[0] !== 16'd1) begin errors++; $display("FAIL midrst_cnt_new: got %0d expected 1", fc[0]); end
  endtask

  task automatic test_gaps();
    int fv_cnt = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(0, 32'hA00 + 32'(i), i == 7);
      if (i < 7) begin
        fv_cnt += int'(fv[0]);
        step();
        fv_cnt += int'(fv[0]);
      end
    end
    checks++;
    if (fv_cnt !== 0) begin errors++; $display("FAIL gaps_early_fv: got %0d pulses expected 0", fv_cnt); end
    checks++;
    if (fv[0] !== 1'b1) begin errors++; $display("FAIL gaps_fv: got %b expected 1", fv[0]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o[0][i] !== 32'hA00 + 32'(i)) begin errors++; $display("FAIL gaps_out%0d: got %h expected %h", i + 1, o[0][i], 32'hA00 + 32'(i)); end
    end
    checks++;
    if (fc[0] !== 16'd1) begin errors++; $display("FAIL gaps_cnt: got %0d expected 1", fc[0]); end
    step();
    checks++;
    if (fv[0] !== 1'b0) begin errors++; $display("FAIL gaps_fv_width: got %b expected 0", fv[0]); end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int f = 0; f < 5; f++) begin
      push_frame(3, 32'hB00 + 32'(16 * f));
      checks++;
      if (fv[3] !== 1'b1) begin errors++; $display("FAIL wrap_fv frame=%0d: got %b expected 1", f, fv[3]); end
      checks++;
      if (fc[3] !== 16'(wr_exp[f])) begin errors++; $display("FAIL wrap_cnt frame=%0d: got %0d expected %0d", f, fc[3], wr_exp[f]); end
      checks++;
      if (o[3][7] !== 32'hB07 + 32'(16 * f)) begin errors++; $display("FAIL wrap_out8 frame=%0d: got %h expected %h", f, o[3][7], 32'hB07 + 32'(16 * f)); end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      s_data[d]  = 32'h0;
      s_valid[d] = 1'b0;
      s_last[d]  = 1'b0;
    end
    test_reset();
    test_stream();
    test_bitrev();
    test_hold();
    test_drop();
    test_reset_mid();
    test_gaps();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft8_frame_loader.md
Name: fft8_frame_loader

Overview:
- Upstream feeder for fft8_fp.
- Accepts a serial stream of complex samples, one per cycle, with a valid/ready handshake, and assembles them into 8-sample frames.
- Presents each complete frame on eight parallel output words (in1..in8 of fft8_fp) and holds it stable for a guaranteed window.
- A one-deep fill buffer behind the output registers lets the next frame load while the current one is held.

Parameters:
- DATA_W, 32, sample width; {real fp16 [31:16], imag fp16 [15:0]}.
- HOLD_CYCLES, 7, minimum extra cycles a presented frame stays stable; range 0..255.
- BIT_REV, 0, 1 = stream index i drives output bitrev3(i)+1; 0 = natural order.
- CNT_W, 16, frame counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  input sample.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the last sample of a frame; qualified by s_valid.
- s_ready  out  1  loader accepts a sample this cycle.
- out1..out8  out  DATA_W each  parallel frame; out1 = sample 0 (natural order).
- frame_valid  out  1  one-cycle pulse in the first cycle a new frame is on out1..out8.
- frame_err  out  1  one-cycle pulse when a frame is dropped on early s_last.
- frame_cnt  out  CNT_W  frames presented since reset; wraps.

Behaviour:
- Reset, clock cycle after rst is sampled high:
  - out1..out8 = 0; frame_valid = 0; frame_err = 0; frame_cnt = 0.
  - idx = 0; hold_cnt = 0; state = FILL.
  - s_ready = 0 while rst is high.
- Reset mid-frame discards the partial frame and any full buffer. No frame_valid or frame_err is produced.
- Accept occurs at a rising edge with s_valid && s_ready. s_ready = (state == FILL) && !rst and is driven from registers only.
- FILL, on accept:
  - buf[idx] <= s_data.
  - s_last && idx != 7: drop frame, idx <= 0, frame_err pulses next cycle. Stays FILL.
  - idx != 7, no s_last: idx++.
  - idx == 7 (s_last ignored here, frame completes): idx <= 0.
    - If hold_cnt == 0: transfer this edge (buf plus the current sample -> out regs), stay FILL.
    - Else: go FULL.
- FULL:
  - s_ready = 0.
  - When hold_cnt == 0: transfer buf -> out regs, go FILL. s_ready = 1 the following cycle.
- Transfer side effects:
  - Applies BIT_REV mapping.
  - hold_cnt <= HOLD_CYCLES.
  - frame_valid = 1 for the next cycle.
  - frame_cnt++ (wraps 2^CNT_W-1 -> 0).
- hold_cnt decrements each cycle while nonzero; it is never reloaded except at transfer.
- Latency: the 8th sample is accepted at edge k; out regs update and frame_valid is high in cycle k+1 when the output is free.
- Each presented frame is stable for at least HOLD_CYCLES+1 cycles.
- With the default HOLD_CYCLES = 7, continuous streaming never deasserts s_ready.
- Simultaneous events:
  - Transfer and hold-counter reload in the same edge: reload wins.
  - s_valid while in FULL is ignored; the sample is not consumed.
- No arithmetic on data: samples pass bit-exact.

Decomposition:
- Shared package fft8_pkg:
  - FFT_N = 8, LOG2N = 3, DATA_W default.
  - fp16 complex field positions.
  - bitrev3 function.
  - Loader state encoding {FILL, FULL}.
- No sub-module. This is one flat block: fill buffer, index counter, hold counter, 2-state FSM.

Test Plan:
- Reset then stream 3c000000, 40000000, 42000000, 44000000, 44000000, 42000000, 40000000, 3c000000 back-to-back (s_last on 8th) -> in the cycle after the 8th accept: out1..out8 equal the stream in order, frame_valid = 1 for exactly 1 cycle, frame_cnt = 1, s_ready never low.
- BIT_REV = 1, stream values 0..7 -> out1..out8 = 0, 4, 2, 6, 1, 5, 3, 7.
- HOLD_CYCLES = 12, two frames back-to-back -> after the 16th sample s_ready = 0 until frame 1 has been stable 13 cycles. Then frame 2 transfers, frame_valid pulses, and s_ready returns the next cycle with no sample lost or duplicated.
- s_last on the 5th sample, then a clean 8-sample frame -> frame_err pulses once, no frame_valid for the dropped frame, the next frame is correct, frame_cnt = 1.
- rst asserted after 4 samples of frame 2, outputs holding frame 1 -> next cycle all outputs 0, frame_cnt = 0, no pulses. A following full frame loads correctly starting at idx 0.
- s_valid toggling every other cycle across 8 samples -> a single frame_valid in the cycle after the 8th accept, correct ordering. frame_cnt wrap checked with CNT_W = 2 over 5 frames -> 1, 2, 3, 0, 1.
